rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter WIDTH, default 5, SHALL set the data width of every requester word and of the output word.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 req  input  4  SHALL carry the per-requester request flags, bit i for requester i.
REQ-005 d0, d1, d2, d3  input  WIDTH each  SHALL carry the per-requester data words.
REQ-006 ack  output  4  SHALL carry a one-hot, one-cycle pulse marking the requester whose word was captured.
REQ-007 out_valid  output  1  SHALL indicate that out_data holds a word awaiting acceptance.
REQ-008 out_ready  input  1  SHALL indicate that the consumer accepts out_data this cycle.
REQ-009 out_data  output  WIDTH  SHALL carry the captured word.
REQ-010 sel  output  2  SHALL carry the index of the current or most recent grant, usable as a 4:1 mux select.

Function
REQ-011 States SHALL be IDLE (no word held) and HOLD (word held, out_valid=1).
REQ-012 Effective request SHALL be eff = req & ~ack; a requester being acked this cycle is ignored.
REQ-013 Winner SHALL be the first set bit of eff searched in order ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-014 IDLE with eff!=0 at an edge SHALL: capture d[winner] into out_data, set sel=winner, pulse ack[winner] for the next cycle, set out_valid=1, and move to HOLD.
REQ-015 IDLE with eff==0 SHALL hold all outputs, with ack=0.
REQ-016 In HOLD, out_data and sel SHALL stay stable until an edge where out_valid&out_ready=1.
REQ-017 On a HOLD handshake edge, ptr SHALL become (sel+1) mod 4.
REQ-018 On a HOLD handshake edge with eff!=0, the block SHALL re-arbitrate in the same edge using the updated ptr and capture the next word per REQ-014, with no bubble cycle.
REQ-019 On a HOLD handshake edge with eff==0, the block SHALL clear out_valid and go to IDLE.
REQ-020 Latency SHALL be one cycle: a req sampled at edge n gives out_valid=1 and ack pulse after edge n.
REQ-021 A requester SHALL deassert req in the cycle its ack is high, or it re-requests; a req dropped before grant SHALL never be acked.
REQ-022 ack SHALL be zero in every cycle that is not immediately after a capture edge.
REQ-023 ptr SHALL wrap from 3 to 0.
REQ-024 Under continuous requests from all four requesters, grants SHALL cycle 0,1,2,3,0,...

Reset
REQ-025 On reset=1 at an edge, the block SHALL set state=IDLE, ptr=0, out_valid=0, ack=0, sel=0, out_data=0, regardless of other inputs.
REQ-026 Reset asserted mid-HOLD SHALL discard the held word with no ack and no handshake side effect.
REQ-027 In the first cycle after reset deasserts, a request SHALL be arbitrated normally from ptr=0.

Structure
REQ-028 A shared package SHALL hold the default WIDTH (5), the requester count constant (4), and the state enum {IDLE, HOLD}.
REQ-029 The combinational rotating priority picker SHALL be a sub-module rr_pick4 (inputs eff and ptr; outputs winner index and any-flag).
REQ-030 The top SHALL contain only the state, ptr, and output registers plus the capture mux.

Verification
REQ-031 Reset then req=0001, d0=5'h0A, out_ready=1: SHALL give out_valid=1, out_data=0A, sel=0, ack=0001 one cycle after the request; then ptr=1 and IDLE after req drops.
REQ-032 req=1111 held with out_ready=1 and d_i=i+1: accepted words SHALL be 01,02,03,04,01 on consecutive cycles, with no gaps.
REQ-033 out_ready=0 for 5 cycles while in HOLD with d1=5'h13 captured: out_data SHALL stay 13, sel SHALL stay 1, ack SHALL pulse once only, and changing d1 SHALL not alter out_data.
REQ-034 ptr=3 and req=0101: SHALL grant requester 0; after its handshake, requester 2 SHALL be granted next.
REQ-035 reset=1 asserted while in HOLD with out_ready=0: next cycle SHALL show out_valid=0, ack=0, sel=0, out_data=0, and a subsequent req=1000 SHALL be granted sel=3.
REQ-036 Simultaneous handshake and new req=0010 while sel=1 is acked-held: SHALL capture requester 1 again only if req[1] persists past its ack; otherwise return to IDLE.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// ============================================================================
// Module   : rr_arbiter4_pkg
// Purpose  : Shared constants and state encoding for the 4-way RR arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter4_pkg;

   localparam int DEFAULT_WIDTH = 5;
   localparam int NUM_REQ       = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module   : rr_pick4
// Purpose  : Rotating-priority picker: first set bit of eff from ptr upward.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
   import rr_arbiter4_pkg::*;
(
   input  logic [NUM_REQ-1:0] eff,
   input  logic [1:0]         ptr,
   output logic [1:0]         winner,
   output logic               any_req
);

   // Walk from the lowest priority offset up so the nearest set bit wins last.
   always_comb begin
      logic [1:0] idx;
      idx     = 2'd0;
      winner  = 2'd0;
      any_req = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (eff[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : 4-requester round-robin arbiter with a one-word valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [WIDTH-1:0]   d0,
   input  logic [WIDTH-1:0]   d1,
   input  logic [WIDTH-1:0]   d2,
   input  logic [WIDTH-1:0]   d3,
   output logic [NUM_REQ-1:0] ack,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [1:0]         sel
);

   state_e               state_q, state_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [1:0]           sel_q, sel_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;

   logic [NUM_REQ-1:0]   eff;
   logic [1:0]           pick_ptr;
   logic [1:0]           winner;
   logic                 any_req;
   logic                 handshake;
   logic                 capture;

   assign handshake = (state_q == HOLD) && out_ready;
   assign eff       = req & ~ack_q;
   // On a handshake the picker already sees the advanced pointer, so no bubble.
   assign pick_ptr  = handshake ? (sel_q + 2'd1) : ptr_q;
   assign capture   = any_req && ((state_q == IDLE) || handshake);

   rr_pick4 u_pick (
      .eff     (eff),
      .ptr     (pick_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = HOLD;
         HOLD:    if (handshake && !any_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d  = handshake ? (sel_q + 2'd1) : ptr_q;
      sel_d  = sel_q;
      data_d = data_q;
      ack_d  = '0;
      if (capture) begin
         sel_d = winner;
         ack_d = 4'b0001 << winner;
         case (winner)
            2'd0:    data_d = d0;
            2'd1:    data_d = d1;
            2'd2:    data_d = d2;
            default: data_d = d3;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= 2'd0;
         sel_q  <= 2'd0;
         data_q <= '0;
         ack_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         sel_q  <= sel_d;
         data_q <= data_d;
         ack_q  <= ack_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_data  = data_q;
   assign sel       = sel_q;
   assign ack       = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Scoreboard bench for rr_arbiter4 with per-scenario directed checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter4;

   typedef struct packed {
      logic       valid;
      logic [4:0] data;
      logic [1:0] sel;
      logic [3:0] ack;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [4:0] d0 = 5'h00, d1 = 5'h00, d2 = 5'h00, d3 = 5'h00;
   logic       out_ready = 1'b0;
   logic [3:0] ack;
   logic       out_valid;
   logic [4:0] out_data;
   logic [1:0] sel;

   int errors = 0;
   int checks = 0;

   exp_t       sb[$];
   logic [5:0] acc_log[$];
   logic       log_en = 1'b0;

   // Reference model state
   logic       m_valid = 1'b0;
   logic [1:0] m_ptr   = 2'd0;
   logic [1:0] m_sel   = 2'd0;
   logic [4:0] m_data  = 5'h00;
   logic [3:0] m_ack   = 4'b0000;

   rr_arbiter4 #(.WIDTH(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   // Predict the post-edge outputs, push them, clock once, then pop and compare.
   task automatic step();
      exp_t       e;
      logic [3:0] eff;
      logic [1:0] idx;
      logic [4:0] dv[4];
      logic       hs, found;
      if (log_en) acc_log.push_back({out_valid && out_ready, out_data});
      dv = '{d0, d1, d2, d3};
      if (reset) begin
         m_valid = 1'b0; m_ptr = 2'd0; m_sel = 2'd0; m_data = 5'h00; m_ack = 4'b0000;
      end else begin
         eff   = req & ~m_ack;
         hs    = m_valid && out_ready;
         found = 1'b0;
         if (hs) m_ptr = m_sel + 2'd1;
         if (!m_valid || hs) begin
            for (int i = 0; i < 4; i++) begin
               idx = m_ptr + 2'(i);
               if (!found && eff[idx]) begin
                  found  = 1'b1;
                  m_sel  = idx;
                  m_data = dv[idx];
               end
            end
         end
         if (found) begin
            m_ack   = 4'b0001 << m_sel;
            m_valid = 1'b1;
         end else begin
            m_ack = 4'b0000;
            if (hs) m_valid = 1'b0;
         end
      end
      e = '{valid: m_valid, data: m_data, sel: m_sel, ack: m_ack};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({out_valid, out_data, sel, ack} !== e) begin
         errors++;
         $display("FAIL scoreboard t=%0t: got valid=%b data=%h sel=%0d ack=%b, need valid=%b data=%h sel=%0d ack=%b",
                  $time, out_valid, out_data, sel, ack, e.valid, e.data, e.sel, e.ack);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; out_ready = 1'b0;
      d0 = 5'h11; d1 = 5'h12; d2 = 5'h13; d3 = 5'h14;
      step();
      step();
      checks++;
      if ({out_valid, out_data, sel, ack} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: got valid=%b data=%h sel=%0d ack=%b, need all zero", out_valid, out_data, sel, ack);
      end
      reset = 1'b0; req = 4'b0000;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001; d0 = 5'h0A; out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 5'h0A || sel !== 2'd0 || ack !== 4'b0001) begin
         errors++;
         $display("FAIL single_grant: got valid=%b data=%h sel=%0d ack=%b, need 1 0a 0 0001", out_valid, out_data, sel, ack);
      end
      req = 4'b0000;
      step();
      checks++;
      if (out_valid !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: got valid=%b ack=%b, need 0 0000", out_valid, ack);
      end
      req = 4'b0011;
      step();
      checks++;
      if (sel !== 2'd1 || ack !== 4'b0010) begin
         errors++;
         $display("FAIL single_ptr_advance: got sel=%0d ack=%b, need 1 0010", sel, ack);
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_w[5];
      exp_w = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h01};
      do_reset();
      d0 = 5'h01; d1 = 5'h02; d2 = 5'h03; d3 = 5'h04;
      req = 4'b1111; out_ready = 1'b1;
      acc_log.delete();
      log_en = 1'b1;
      repeat (6) step();
      log_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (acc_log.size() < i + 2 || acc_log[i + 1] !== {1'b1, exp_w[i]}) begin
            errors++;
            $display("FAIL b2b_word%0d: got %h, need accepted %h", i,
                     (acc_log.size() >= i + 2) ? acc_log[i + 1] : 6'h00, {1'b1, exp_w[i]});
         end
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_stall();
      int ack_cnt;
      do_reset();
      req = 4'b0010; d1 = 5'h13; out_ready = 1'b0;
      step();
      ack_cnt = (ack != 4'b0000) ? 1 : 0;
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         d1 = 5'($urandom_range(0, 31));
         step();
         if (ack != 4'b0000) ack_cnt++;
         checks++;
         if (out_data !== 5'h13 || sel !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: got data=%h sel=%0d valid=%b, need 13 1 1", i, out_data, sel, out_valid);
         end
      end
      checks++;
      if (ack_cnt !== 1) begin
         errors++;
         $display("FAIL stall_ack_pulses: got %0d, need 1", ack_cnt);
      end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_wrap();
      do_reset();
      req = 4'b0100; out_ready = 1'b1;
      step();
      req = 4'b0000;
      step();
      req = 4'b0101; out_ready = 1'b0;
      step();
      checks++;
      if (sel !== 2'd0 || ack !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_grant0: got sel=%0d ack=%b, need 0 0001", sel, ack);
      end
      req = 4'b0100; out_ready = 1'b1;
      step();
      checks++;
      if (sel !== 2'd2 || ack !== 4'b0100 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_grant2: got sel=%0d ack=%b valid=%b, need 2 0100 1", sel, ack, out_valid);
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_reset_hold();
      do_reset();
      req = 4'b0010; d1 = 5'h1C; out_ready = 1'b0;
      step();
      req = 4'b0000;
      step();
      reset = 1'b1; req = 4'b1111;
      step();
      checks++;
      if ({out_valid, out_data, sel, ack} !== 12'h000) begin
         errors++;
         $display("FAIL reset_in_hold: got valid=%b data=%h sel=%0d ack=%b, need all zero", out_valid, out_data, sel, ack);
      end
      reset = 1'b0; req = 4'b1000; d3 = 5'h07;
      step();
      checks++;
      if (sel !== 2'd3 || ack !== 4'b1000 || out_valid !== 1'b1 || out_data !== 5'h07) begin
         errors++;
         $display("FAIL reset_then_req3: got sel=%0d ack=%b valid=%b data=%h, need 3 1000 1 07", sel, ack, out_valid, out_data);
      end
      req = 4'b0000; out_ready = 1'b1;
      step();
   endtask

   task automatic test_rereq();
      do_reset();
      req = 4'b0010; d1 = 5'h15; out_ready = 1'b0;
      step();
      step();
      out_ready = 1'b1;
      step();
      checks++;
      if (sel !== 2'd1 || ack !== 4'b0010 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rereq_persist: got sel=%0d ack=%b valid=%b, need 1 0010 1", sel, ack, out_valid);
      end
      req = 4'b0000;
      step();
      checks++;
      if (out_valid !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL rereq_dropped: got valid=%b ack=%b, need 0 0000", out_valid, ack);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_wrap();
      test_reset_hold();
      test_rereq();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
